matrix_mult_scheduler: RTL and testbench
========================================

Name: matrix_mult_scheduler

Overview:
- Sequential controller that computes C = A x B for square matrices of run-time size N (1..MAX_SIZE).
- Streams A and B from external synchronous-read memories through one shared multiply-accumulate datapath, one MAC per cycle, and writes each C element to an external result memory.
- Low-area alternative to the fully parallel multiplier; uses the same row-major element layout, where element [r][c] is at address r*MAX_SIZE + c.

Parameters:
- MAX_SIZE, 10, maximum matrix dimension.
- DATA_W, 32, element width; products and sums are truncated to DATA_W.
- ADDR_W, $clog2(MAX_SIZE*MAX_SIZE), memory address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- matrix_size  in  32  N; latched when start is accepted.
- abort  in  1  synchronous cancel of a running job.
- busy  out  1  high from the cycle after start acceptance until done/abort.
- done  out  1  one-cycle pulse at job end, including error jobs.
- err  out  1  one-cycle pulse with done when N is invalid.
- a_rd_en / b_rd_en  out  1  read strobes for A and B memories.
- a_rd_addr / b_rd_addr  out  ADDR_W  read addresses.
- a_rd_data / b_rd_data  in  DATA_W  read data, valid exactly 1 cycle after rd_en.
- c_wr_en  out  1  result write strobe.
- c_wr_addr  out  ADDR_W  result address.
- c_wr_data  out  DATA_W  result value.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; all outputs 0; counters, accumulator and pipeline valids cleared.
- Validation: start in IDLE latches N.
  - N==0 or N>MAX_SIZE: go to ERR.
  - ERR lasts one cycle with done=1, err=1, busy=0. No memory access occurs.
- FSM states: IDLE -> RUN -> DRAIN -> FIN -> IDLE.
  - IDLE -> ERR -> IDLE on an invalid N.
- RUN, issue stage:
  - Loop i (outer), j, k (inner), each 0..N-1.
  - Each cycle: a_rd_en=b_rd_en=1, a_rd_addr=i*MAX_SIZE+k, b_rd_addr=k*MAX_SIZE+j.
  - Tags first=(k==0), last=(k==N-1), and c address i*MAX_SIZE+j are pipelined along with the read.
  - Exactly N^3 issue cycles, with no bubbles. After the issue of (N-1,N-1,N-1), go to DRAIN.
- Stage 1, the cycle after issue:
  - acc <= (first ? 0 : acc) + lo(a_rd_data*b_rd_data).
  - Arithmetic is modulo 2^DATA_W and unsigned.
- Stage 2, the cycle after a last-tagged stage 1: c_wr_en=1, c_wr_data=acc, c_wr_addr=tagged address.
  - One write per (i,j), in row-major order.
  - Write cycles overlap with continued issue. No stalls.
- DRAIN: 2 cycles to flush stages 1 and 2. FIN: done=1 for one cycle, busy=0, then IDLE.
- Timing, with start accepted at edge 0:
  - Issues occur in cycles 1..N^3.
  - The final write occurs in cycle N^3+2.
  - done pulses in cycle N^3+3.
  - busy is high in cycles 1..N^3+2.
- Address arithmetic: computed from counters with multiplies by the constant MAX_SIZE. Incremental row-base registers are acceptable. No address exceeds MAX_SIZE^2-1.
- start while busy (RUN/DRAIN/FIN): ignored, with no effect on latched N.
- abort:
  - In RUN or DRAIN: next cycle enters IDLE, clears pipeline valids, and suppresses any pending c_wr_en. No done, no err.
  - In IDLE: no effect.
  - abort and start in the same IDLE cycle: start is accepted.
- Async reset mid-job: everything is immediately cleared and no further writes occur.
- Unused upper bits of matrix_size participate in validation; for example, 0x1_0000_0002 is impossible, but 32'hFFFF_FFFF is invalid.

Decomposition:
- Package matrix_mult_pkg holds:
  - MAX_SIZE and DATA_W defaults.
  - The ADDR_W function.
  - The FSM state enum (IDLE, RUN, DRAIN, FIN, ERR).
- Sub-module mac_unit: a registered multiply-accumulate with inputs a, b, first, valid and outputs acc, acc_valid. It is reusable by future tiled variants.
- The scheduler contains the loop counters, address generation, tag pipeline, and FSM.

Test Plan:
- N=1, A[0]=3, B[0]=4, start at cycle 0:
  - Exactly one write, C[0]=12, in cycle 3.
  - done in cycle 4; busy high in cycles 1..3.
- N=2, MAX_SIZE=10, A=[[1,2],[3,4]], B=[[5,6],[7,8]]:
  - Writes in order: addr 0=19, 1=22, 10=43, 11=50.
  - 8 issue cycles; done at cycle 11.
- N=10, A=identity, B[r][c]=r*10+c:
  - C equals B.
  - 100 writes; done at cycle 1003; no address >99.
- Wrap: N=1, A=0x0001_0000, B=0x0001_0000 -> C=0.
- Wrap: N=2, row0 of A = {0xFFFF_FFFF, 1}, column0 of B = {1, 1} -> C[0][0]=0.
- Invalid N=0 and N=11: done=err=1 for one cycle after start; no rd_en or wr_en ever asserted; busy stays 0.
- Control edge cases, N=3:
  - A start pulse at cycle 5 has no effect.
  - abort at cycle 10 -> IDLE at 11.
  - No writes after cycle 11; no done.
  - A new start then completes normally with correct results.

Source files
------------

// File: rtl/matrix_mult_pkg.sv
// Shared definitions for the matrix multiply scheduler and its MAC datapath.
// Holds the default geometry, the address-width helper, and the FSM state type.
package matrix_mult_pkg;

  localparam int MAX_SIZE_DEF = 10;
  localparam int DATA_W_DEF   = 32;

  // Width needed to address every element of a MAX_SIZE x MAX_SIZE matrix.
  function automatic int addr_w(input int max_size);
    int w;
    w = $clog2(max_size * max_size);
    return (w < 1) ? 1 : w;
  endfunction

  // Width of a loop counter that walks 0..max_size-1 and may step one past.
  function automatic int cnt_w(input int max_size);
    int w;
    w = $clog2(max_size + 1);
    return (w < 1) ? 1 : w;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN,
    ERR
  } state_t;

endpackage

// File: rtl/mac_unit.sv
// Registered multiply-accumulate stage.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   clear       - drops the current operand so nothing is accumulated or flagged
//   a, b        - operands; product truncated to DATA_W, unsigned
//   first       - restart the running sum with this product
//   valid       - operands are meaningful this cycle
//   acc         - running sum (modulo 2^DATA_W)
//   acc_valid   - acc was updated on the last edge
module mac_unit
  import matrix_mult_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              first,
  input  logic              valid,
  output logic [DATA_W-1:0] acc,
  output logic              acc_valid
);

  logic [DATA_W-1:0] base;
  logic              take;

  assign base = first ? '0 : acc;
  assign take = valid && !clear;

  // Accumulate only on valid operands so idle cycles leave the sum intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      acc_valid <= 1'b0;
    end else begin
      acc_valid <= take;
      if (take) begin
        acc <= base + a * b;
      end
    end
  end

endmodule

// File: rtl/matrix_mult_scheduler.sv
// Sequential C = A x B controller: one MAC per cycle over an i/j/k loop nest,
// reading A and B from synchronous-read memories and writing each C element.
// Ports:
//   clk, rst_n               - clock and asynchronous active-low reset
//   start, matrix_size       - job request and its dimension N
//   abort                    - cancel a running job
//   busy, done, err          - job status
//   a_rd_* / b_rd_*          - operand memory read ports (data 1 cycle after en)
//   c_wr_*                   - result memory write port
module matrix_mult_scheduler
  import matrix_mult_pkg::*;
#(
  parameter int MAX_SIZE = MAX_SIZE_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = addr_w(MAX_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       matrix_size,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_rd_addr,
  input  logic [DATA_W-1:0] a_rd_data,
  output logic              b_rd_en,
  output logic [ADDR_W-1:0] b_rd_addr,
  input  logic [DATA_W-1:0] b_rd_data,
  output logic              c_wr_en,
  output logic [ADDR_W-1:0] c_wr_addr,
  output logic [DATA_W-1:0] c_wr_data
);

  localparam int                CNT_W      = cnt_w(MAX_SIZE);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(MAX_SIZE);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  n_m1, i_cnt, j_cnt, k_cnt;
  logic              drain_cnt;
  logic              n_valid, issue, kill, last_issue;
  logic [ADDR_W-1:0] c_issue_addr;
  logic              s1_valid, s1_first, s1_last, s2_last;
  logic [ADDR_W-1:0] s1_addr, s2_addr;
  logic [DATA_W-1:0] acc;
  logic              acc_valid;

  // The full 32-bit size is compared so stray upper bits mark the job invalid.
  assign n_valid    = (matrix_size != 32'd0) && (matrix_size <= 32'(MAX_SIZE));
  assign issue      = (state == RUN);
  assign kill       = abort && ((state == RUN) || (state == DRAIN));
  assign last_issue = issue && (i_cnt == n_m1) && (j_cnt == n_m1) && (k_cnt == n_m1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; DRAIN holds two cycles so the last product reaches C.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = n_valid ? RUN : ERR;
      RUN:     if (kill) state_nxt = IDLE;
               else if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (kill) state_nxt = IDLE;
               else if (drain_cnt) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latched size and the k-innermost loop counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_m1      <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      k_cnt     <= '0;
      drain_cnt <= 1'b0;
    end else begin
      if ((state == IDLE) && start && n_valid) begin
        n_m1  <= CNT_W'(matrix_size - 32'd1);
        i_cnt <= '0;
        j_cnt <= '0;
        k_cnt <= '0;
      end else if (issue) begin
        if (k_cnt == n_m1) begin
          k_cnt <= '0;
          if (j_cnt == n_m1) begin
            j_cnt <= '0;
            i_cnt <= i_cnt + 1'b1;
          end else begin
            j_cnt <= j_cnt + 1'b1;
          end
        end else begin
          k_cnt <= k_cnt + 1'b1;
        end
      end
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  assign a_rd_en      = issue;
  assign b_rd_en      = issue;
  assign a_rd_addr    = issue ? ADDR_W'(i_cnt) * ROW_STRIDE + ADDR_W'(k_cnt) : '0;
  assign b_rd_addr    = issue ? ADDR_W'(k_cnt) * ROW_STRIDE + ADDR_W'(j_cnt) : '0;
  assign c_issue_addr = ADDR_W'(i_cnt) * ROW_STRIDE + ADDR_W'(j_cnt);

  // Tags travel alongside the read so they line up with the returning data
  // (stage 1) and with the finished sum (stage 2). Abort drops the in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_addr  <= '0;
      s2_last  <= 1'b0;
      s2_addr  <= '0;
    end else begin
      s1_valid <= issue && !kill;
      s1_first <= (k_cnt == '0);
      s1_last  <= (k_cnt == n_m1);
      s1_addr  <= c_issue_addr;
      s2_last  <= s1_last;
      s2_addr  <= s1_addr;
    end
  end

  // Clearing on abort keeps a product already in stage 1 from becoming a write.
  mac_unit #(.DATA_W(DATA_W)) u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (kill),
    .a         (a_rd_data),
    .b         (b_rd_data),
    .first     (s1_first),
    .valid     (s1_valid),
    .acc       (acc),
    .acc_valid (acc_valid)
  );

  assign c_wr_en   = acc_valid && s2_last;
  assign c_wr_addr = c_wr_en ? s2_addr : '0;
  assign c_wr_data = c_wr_en ? acc : '0;

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == FIN) || (state == ERR);
  assign err  = (state == ERR);

endmodule

// File: tb/tb_matrix_mult_scheduler.sv
// Randomized self-checking bench for matrix_mult_scheduler. A cycle-indexed
// job model predicts every output from the job's start cycle, N and the
// memory contents; literal expectations pin the worked examples.
module tb_matrix_mult_scheduler;

  localparam int MS = 10;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [31:0] matrix_size;
  logic        busy, done, err, a_rd_en, b_rd_en, c_wr_en;
  logic [6:0]  a_rd_addr, b_rd_addr, c_wr_addr;
  logic [31:0] a_rd_data = '0;
  logic [31:0] b_rd_data = '0;
  logic [31:0] c_wr_data;

  logic [31:0] a_mem [0:127];
  logic [31:0] b_mem [0:127];
  logic [31:0] c_got [0:127];

  int checks = 0;
  int failures = 0;

  bit job_on = 1'b0;
  bit job_err = 1'b0;
  int job_n = 0, job_n3 = 0, job_cyc = 0;
  int wr_count = 0, rd_count = 0, done_count = 0, err_count = 0;
  int wr_last_cyc = 0, last_done_cyc = 0;

  always #5 clk = ~clk;

  matrix_mult_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .matrix_size (matrix_size),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .a_rd_en     (a_rd_en),
    .a_rd_addr   (a_rd_addr),
    .a_rd_data   (a_rd_data),
    .b_rd_en     (b_rd_en),
    .b_rd_addr   (b_rd_addr),
    .b_rd_data   (b_rd_data),
    .c_wr_en     (c_wr_en),
    .c_wr_addr   (c_wr_addr),
    .c_wr_data   (c_wr_data)
  );

  // Synchronous-read operand memories.
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
    if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_c(input int r, input int c, input int n);
    logic [31:0] sum;
    sum = '0;
    for (int k = 0; k < n; k++) sum = sum + a_mem[r*MS+k] * b_mem[k*MS+c];
    return sum;
  endfunction

  // Job model stepped at each edge, then every output compared 1 time unit later.
  always @(posedge clk) begin
    int t, u, w, ea, eb, ec;
    logic e_busy, e_done, e_err, e_rd, e_wr;
    logic [31:0] ed;
    if (!rst_n) begin
      job_on = 1'b0;
    end else if (job_on) begin
      if (!job_err && abort && job_cyc <= job_n3 + 2) begin
        job_on = 1'b0;
      end else begin
        job_cyc++;
        if (job_err ? (job_cyc > 1) : (job_cyc > job_n3 + 3)) job_on = 1'b0;
      end
    end else if (start) begin
      job_on  = 1'b1;
      job_cyc = 1;
      job_err = (matrix_size == 32'd0) || (matrix_size > 32'd10);
      job_n   = job_err ? 0 : int'(matrix_size);
      job_n3  = job_n * job_n * job_n;
    end
    #1;
    if (rst_n) begin
      e_busy = 0; e_done = 0; e_err = 0; e_rd = 0; e_wr = 0;
      ea = 0; eb = 0; ec = 0; ed = '0;
      if (job_on && job_err) begin
        e_done = (job_cyc == 1);
        e_err  = (job_cyc == 1);
      end else if (job_on) begin
        e_busy = (job_cyc <= job_n3 + 2);
        e_done = (job_cyc == job_n3 + 3);
        if (job_cyc <= job_n3) begin
          t    = job_cyc - 1;
          e_rd = 1;
          ea   = (t / (job_n*job_n)) * MS + (t % job_n);
          eb   = (t % job_n) * MS + ((t / job_n) % job_n);
        end
        u = job_cyc - 3;
        if (u >= 0 && u < job_n3 && (u % job_n) == job_n - 1) begin
          w    = u / job_n;
          e_wr = 1;
          ec   = (w / job_n) * MS + (w % job_n);
          ed   = ref_c(w / job_n, w % job_n, job_n);
        end
      end
      checkOutput("busy", 64'(busy), 64'(e_busy));
      checkOutput("done", 64'(done), 64'(e_done));
      checkOutput("err", 64'(err), 64'(e_err));
      checkOutput("a_rd_en", 64'(a_rd_en), 64'(e_rd));
      checkOutput("b_rd_en", 64'(b_rd_en), 64'(e_rd));
      checkOutput("c_wr_en", 64'(c_wr_en), 64'(e_wr));
      if (e_rd) begin
        checkOutput("a_rd_addr", 64'(a_rd_addr), 64'(ea));
        checkOutput("b_rd_addr", 64'(b_rd_addr), 64'(eb));
      end
      if (e_wr) begin
        checkOutput("c_wr_addr", 64'(c_wr_addr), 64'(ec));
        checkOutput("c_wr_data", 64'(c_wr_data), 64'(ed));
      end
      if (c_wr_en) begin
        c_got[c_wr_addr] = c_wr_data;
        wr_count++;
        wr_last_cyc = job_cyc;
      end
      if (a_rd_en || b_rd_en) rd_count++;
      if (done) begin
        done_count++;
        last_done_cyc = job_cyc;
        if (err) err_count++;
      end
    end
  end

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_err"}, 64'(err), 64'd0);
    checkOutput({tag, "_a_rd_en"}, 64'(a_rd_en), 64'd0);
    checkOutput({tag, "_b_rd_en"}, 64'(b_rd_en), 64'd0);
    checkOutput({tag, "_c_wr_en"}, 64'(c_wr_en), 64'd0);
    checkOutput({tag, "_a_rd_addr"}, 64'(a_rd_addr), 64'd0);
    checkOutput({tag, "_b_rd_addr"}, 64'(b_rd_addr), 64'd0);
    checkOutput({tag, "_c_wr_addr"}, 64'(c_wr_addr), 64'd0);
    checkOutput({tag, "_c_wr_data"}, 64'(c_wr_data), 64'd0);
  endtask

  // Start a job in cycle 0; abort_at/spur_at name the cycle for an abort or a
  // stray start (-1 = none, abort_at 0 = abort together with start).
  task automatic applyStimulus(input logic [31:0] n, input int abort_at, input int spur_at, input int budget);
    int  cnt;
    bit  finished;
    @(negedge clk);
    start = 1'b1;
    matrix_size = n;
    abort = (abort_at == 0);
    cnt = 0;
    finished = 1'b0;
    while (cnt < budget) begin
      @(negedge clk);
      cnt++;
      start = 1'b0;
      abort = 1'b0;
      if (!busy && !done) begin
        finished = 1'b1;
        break;
      end
      if (cnt == abort_at) abort = 1'b1;
      if (cnt == spur_at) begin
        start = 1'b1;
        matrix_size = $urandom_range(1, 10);
      end
    end
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (!finished) begin
      failures++;
      $display("[TB] FAIL job_timeout actual=%0d required<%0d", cnt, budget);
    end
  endtask

  initial begin
    int wc0, rc0, dc0, ec0, n, n3, ab, sp;
    logic [31:0] bad [0:3];
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; matrix_size = '0;
    for (int a = 0; a < 128; a++) begin
      a_mem[a] = '0; b_mem[a] = '0; c_got[a] = 32'hDEAD_BEEF;
    end
    #2;
    checkQuiet("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] N=1 scalar");
    a_mem[0] = 3; b_mem[0] = 4;
    wc0 = wr_count;
    applyStimulus(1, -1, -1, 50);
    checkOutput("n1_writes", 64'(wr_count - wc0), 64'd1);
    checkOutput("n1_c0", 64'(c_got[0]), 64'd12);
    checkOutput("n1_wr_cycle", 64'(wr_last_cyc), 64'd3);
    checkOutput("n1_done_cycle", 64'(last_done_cyc), 64'd4);
    checkOutput("n1_model_pin", 64'(ref_c(0, 0, 1)), 64'd12);

    $display("[TB] N=2 worked example");
    a_mem[0] = 1; a_mem[1] = 2; a_mem[10] = 3; a_mem[11] = 4;
    b_mem[0] = 5; b_mem[1] = 6; b_mem[10] = 7; b_mem[11] = 8;
    wc0 = wr_count; rc0 = rd_count;
    applyStimulus(2, -1, -1, 50);
    checkOutput("n2_c00", 64'(c_got[0]), 64'd19);
    checkOutput("n2_c01", 64'(c_got[1]), 64'd22);
    checkOutput("n2_c10", 64'(c_got[10]), 64'd43);
    checkOutput("n2_c11", 64'(c_got[11]), 64'd50);
    checkOutput("n2_writes", 64'(wr_count - wc0), 64'd4);
    checkOutput("n2_issues", 64'(rd_count - rc0), 64'd8);
    checkOutput("n2_done_cycle", 64'(last_done_cyc), 64'd11);

    $display("[TB] wrap cases");
    a_mem[0] = 32'hFFFF_FFFF; a_mem[1] = 1; b_mem[0] = 1; b_mem[10] = 1;
    applyStimulus(2, -1, -1, 50);
    checkOutput("wrap2_c00", 64'(c_got[0]), 64'd0);
    a_mem[0] = 32'h0001_0000; b_mem[0] = 32'h0001_0000;
    wc0 = wr_count;
    applyStimulus(1, -1, -1, 50);
    checkOutput("wrap1_c0", 64'(c_got[0]), 64'd0);
    checkOutput("wrap1_writes", 64'(wr_count - wc0), 64'd1);

    $display("[TB] N=10 identity");
    for (int r = 0; r < MS; r++)
      for (int c = 0; c < MS; c++) begin
        a_mem[r*MS+c] = (r == c) ? 32'd1 : 32'd0;
        b_mem[r*MS+c] = 32'(r*MS + c);
      end
    wc0 = wr_count;
    applyStimulus(10, -1, -1, 1100);
    checkOutput("n10_writes", 64'(wr_count - wc0), 64'd100);
    checkOutput("n10_done_cycle", 64'(last_done_cyc), 64'd1003);
    for (int a = 0; a < 100; a++) checkOutput("n10_c_eq_b", 64'(c_got[a]), 64'(a));

    $display("[TB] invalid sizes");
    bad[0] = 32'd0; bad[1] = 32'd11; bad[2] = 32'hFFFF_FFFF; bad[3] = 32'h8000_0002;
    for (int v = 0; v < 4; v++) begin
      wc0 = wr_count; rc0 = rd_count; ec0 = err_count;
      applyStimulus(bad[v], -1, -1, 20);
      checkOutput("bad_writes", 64'(wr_count - wc0), 64'd0);
      checkOutput("bad_reads", 64'(rd_count - rc0), 64'd0);
      checkOutput("bad_err_pulses", 64'(err_count - ec0), 64'd1);
      checkOutput("bad_done_cycle", 64'(last_done_cyc), 64'd1);
    end

    $display("[TB] N=3 stray start and abort");
    for (int a = 0; a < 100; a++) begin
      a_mem[a] = $urandom_range(0, 255); b_mem[a] = $urandom_range(0, 255);
    end
    wc0 = wr_count; dc0 = done_count;
    applyStimulus(3, 10, 5, 60);
    repeat (20) @(negedge clk);
    checkOutput("abort_writes", 64'(wr_count - wc0), 64'd2);
    checkOutput("abort_no_done", 64'(done_count - dc0), 64'd0);
    wc0 = wr_count;
    applyStimulus(3, -1, -1, 60);
    checkOutput("restart_writes", 64'(wr_count - wc0), 64'd9);
    checkOutput("restart_done_cycle", 64'(last_done_cyc), 64'd30);
    for (int a = 0; a < 9; a++)
      checkOutput("restart_c", 64'(c_got[(a/3)*MS + a%3]), 64'(ref_c(a/3, a%3, 3)));

    $display("[TB] abort with start in idle");
    dc0 = done_count;
    applyStimulus(2, 0, -1, 50);
    checkOutput("abort_start_done", 64'(done_count - dc0), 64'd1);

    $display("[TB] async reset mid-job");
    @(negedge clk);
    start = 1'b1; matrix_size = 4;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkQuiet("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wc0 = wr_count; dc0 = done_count;
    repeat (20) @(negedge clk);
    checkOutput("midreset_writes", 64'(wr_count - wc0), 64'd0);
    checkOutput("midreset_done", 64'(done_count - dc0), 64'd0);

    $display("[TB] randomized jobs");
    for (int j = 0; j < 30; j++) begin
      for (int a = 0; a < 100; a++) begin
        a_mem[a] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 15);
        b_mem[a] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 15);
      end
      ab = -1; sp = -1;
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0: n = 0;
          1: n = 11;
          2: n = int'($urandom_range(12, 100000));
          default: n = int'({1'b1, 31'($urandom_range(1, 10))});
        endcase
        n3 = 0;
      end else begin
        n  = $urandom_range(1, 4);
        n3 = n * n * n;
        if ($urandom_range(0, 3) == 0) ab = $urandom_range(1, n3 + 2);
        if ($urandom_range(0, 2) == 0) begin
          if (ab < 0) sp = $urandom_range(1, n3 + 2);
          else if (ab > 1) sp = $urandom_range(1, ab - 1);
        end
      end
      applyStimulus(32'(n), ab, sp, n3 + 20);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
